router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to send a packet; sampled only in IDLE.
REQ-005 dest  input  2  destination port (0..2), latched on accepted start.
REQ-006 len  input  6  payload byte count (1..63), latched on accepted start.
REQ-007 pl_data  input  8  payload byte from the upstream source.
REQ-008 pl_valid  input  1  pl_data is valid.
REQ-009 pl_ready  output  1  payload byte is consumed at this edge.
REQ-010 busy  input  1  router busy; while high, the byte on data_out is not taken.
REQ-011 data_out  output  8  byte driven to the router's data_in.
REQ-012 pkt_valid  output  1  high for the header and payload bytes, low for the parity byte.
REQ-013 tx_busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when the parity byte is accepted.
REQ-015 req_err  output  1  one-cycle pulse when a start request is rejected.
REQ-016 inject_err  input  1  parity-corruption request (see Configuration).

Function
REQ-017 States SHALL be IDLE, HEADER, PAYLOAD, PARITY.
- Transitions: IDLE->HEADER on a valid start; HEADER->PAYLOAD on header acceptance; PAYLOAD->PARITY on last-byte acceptance; PARITY->IDLE on parity acceptance.
REQ-018 A byte SHALL be accepted on a rising edge where the byte is presented and busy=0.
- While busy=1, data_out and pkt_valid SHALL hold their values.
REQ-019 Start validity: start with dest=3 or len=0 SHALL be rejected.
- Response: req_err pulses on the next cycle, the state remains IDLE, and nothing is driven.
REQ-020 HEADER SHALL drive data_out={len,dest} with pkt_valid=1 in the cycle after start is accepted.
REQ-021 PAYLOAD SHALL present pl_data with pkt_valid=1 only while pl_valid=1.
- pl_ready = (state==PAYLOAD) & pl_valid & ~busy.
- If pl_valid=0, pkt_valid SHALL be 0 and the byte count SHALL hold.
REQ-022 A 6-bit down-counter SHALL be loaded with len and decremented on each payload acceptance; the transition to PARITY occurs when the count reaches 0.
REQ-023 Parity SHALL be the 8-bit XOR of the header and all accepted payload bytes.
- The accumulator is cleared on an accepted start.
REQ-024 PARITY SHALL drive the parity byte with pkt_valid=0 and hold it until busy=0.
- On acceptance, done pulses and the block returns to IDLE.
REQ-025 A start asserted while the state is not IDLE SHALL be ignored without a req_err pulse.
REQ-026 Minimum packet time SHALL be len+2 accepted cycles.
- The next start SHALL be accepted no earlier than the cycle after done.

Reset
REQ-027 Reset SHALL asynchronously force the following:
- state=IDLE, data_out=0, pkt_valid=0, pl_ready=0, tx_busy=0, done=0, req_err=0, counter=0, parity=0.
REQ-028 Reset mid-packet SHALL abandon the packet immediately; no parity byte is sent after release.

Configuration
REQ-029 Macro ROUTER_TX_PARITY_INJ_EN.
- Defined: if inject_err=1 when start is accepted, the sent parity byte SHALL be the true parity XOR 8'h01.
- Undefined: inject_err SHALL be ignored and parity is always correct.

Structure
REQ-030 A shared router_pkg SHALL hold:
- state typedef
- address constants ADDR0..ADDR2 and ADDR_INVALID=2'b11
- MAX_LEN=63.
REQ-031 One sub-module, router_tx_parity (clear, enable, byte in, 8-bit accumulator), SHALL be used.

Verification
REQ-032 dest=1, len=3, payload A1,B2,C3, busy=0 throughout:
- data_out sequence 0D,A1,B2,C3,DD.
- pkt_valid=1,1,1,1,0.
- done pulses once.
REQ-033 Same packet with busy=1 for 2 cycles after the header: header 0D held 2 extra cycles, then the sequence proceeds unchanged; parity DD.
REQ-034 start with dest=3 (or len=0): req_err pulses once, tx_busy stays 0, pkt_valid stays 0.
REQ-035 pl_valid dropped for 3 cycles mid-payload: pkt_valid=0 and pl_ready=0 in those cycles, counter holds, packet completes with correct parity.
REQ-036 Reset asserted during PAYLOAD: all outputs become 0 in the same cycle, and a new start after release sends a clean packet.
REQ-037 ROUTER_TX_PARITY_INJ_EN defined with inject_err=1 on the REQ-032 packet: parity byte DC, and the router flags error.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR0        = 2'b00;
  localparam logic [1:0] ADDR1        = 2'b01;
  localparam logic [1:0] ADDR2        = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int unsigned MAX_LEN = 63;

  // Bit flipped in the parity byte when corruption is requested.
  localparam logic [7:0] INJ_MASK = 8'h01;

  // A start is usable only for a real port and a non-empty payload.
  function automatic logic start_ok(input logic [1:0] dest, input logic [5:0] len);
    return (dest inside {ADDR0, ADDR1, ADDR2}) && (len != 6'd0);
  endfunction

endpackage

// File: rtl/router_tx_parity.sv
// Running XOR accumulator over the bytes of one packet.
module router_tx_parity (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] byte_in,
  output logic [7:0] acc
);

  // Clear has priority so a new packet always starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (reset)       acc <= '0;
    else if (clear)  acc <= '0;
    else if (enable) acc <= acc ^ byte_in;
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding a router: header {len,dest}, payload, parity.
// Optional feature: define ROUTER_TX_PARITY_INJ_EN to allow deliberate
// parity corruption via inject_err latched at start acceptance.
//
// data_out/pkt_valid are decoded from registered state; in PAYLOAD they pass
// pl_data/pl_valid straight through, and the upstream source holds its byte
// until pl_ready, so the byte on data_out is stable while busy is high.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_busy,
  output logic       done,
  output logic       req_err,
  input  logic       inject_err
);

  state_t     state;
  logic [7:0] hdr;
  logic [5:0] count;
  logic [7:0] par_acc;
  logic       inj;
  logic       accept_start;
  logic       hdr_take;

  assign accept_start = (state == IDLE) && start && start_ok(dest, len);
  assign hdr_take     = (state == HEADER) && !busy;
  assign pl_ready     = (state == PAYLOAD) && pl_valid && !busy;

  router_tx_parity u_parity (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept_start),
    .enable  (hdr_take || pl_ready),
    .byte_in (hdr_take ? hdr : pl_data),
    .acc     (par_acc)
  );

`ifdef ROUTER_TX_PARITY_INJ_EN
  // Remember the corruption request for the whole packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             inj <= 1'b0;
    else if (accept_start) inj <= inject_err;
  end
`else
  logic unused_inject;
  assign unused_inject = inject_err;
  assign inj           = 1'b0;
`endif

  // Byte presented to the router for the current state.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    data_out  = '0;
    pkt_valid = 1'b0;
    case (state)
      HEADER: begin
        data_out  = hdr;
        pkt_valid = 1'b1;
      end
      PAYLOAD: begin
        if (pl_valid) begin
          data_out  = pl_data;
          pkt_valid = 1'b1;
        end
      end
      PARITY:  data_out = par_acc ^ (inj ? INJ_MASK : 8'h00);
      default: ;
    endcase
  end

  // Packet sequencing FSM with registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hdr     <= '0;
      count   <= '0;
      tx_busy <= 1'b0;
      done    <= 1'b0;
      req_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_start) begin
            hdr     <= {len, dest};
            count   <= len;
            tx_busy <= 1'b1;
            state   <= HEADER;
          end else if (start) begin
            req_err <= 1'b1;
          end
        end
        HEADER: begin
          if (hdr_take) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (pl_ready) begin
            count <= count - 6'd1;
            if (count == 6'd1) state <= PARITY;
          end
        end
        PARITY: begin
          if (!busy) begin
            done    <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: table of packets plus hand-written
// busy-stall, payload-gap and mid-packet reset sequences.
module tb_router_pkt_tx;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_busy;
  logic       done;
  logic       req_err;
  logic       inject_err;

  router_pkt_tx dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dest       (dest),
    .len        (len),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .busy       (busy),
    .data_out   (data_out),
    .pkt_valid  (pkt_valid),
    .tx_busy    (tx_busy),
    .done       (done),
    .req_err    (req_err),
    .inject_err (inject_err)
  );

  always #5 clock = ~clock;

`ifdef ROUTER_TX_PARITY_INJ_EN
  localparam bit INJ_BUILD = 1'b1;
`else
  localparam bit INJ_BUILD = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       pv;
  } exp_t;

  typedef struct {
    logic [1:0] d;
    logic [5:0] l;
    logic [7:0] first;
    logic [7:0] step;
    logic       inj;
    logic       rej;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;
  logic done_exp = 1'b0;
  logic popped_par;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every presented byte against the queue and
  // pops it when the router takes it (busy low).
  always @(negedge clock) begin
    if (!reset) begin
      popped_par = 1'b0;
      check("done", done, done_exp);
      if (!tx_busy) check("idle_pkt_valid", pkt_valid, 1'b0);
      if (tx_busy && (pkt_valid || (exp_q.size() > 0 && !exp_q[0].pv))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {7'd0, pkt_valid, data_out}, 16'h0000);
        end else begin
          check(busy ? "hold_data" : "data", data_out, exp_q[0].data);
          check(busy ? "hold_pkt_valid" : "pkt_valid", pkt_valid, exp_q[0].pv);
          if (!busy) begin
            popped_par = !exp_q[0].pv;
            void'(exp_q.pop_front());
          end
        end
      end
      done_exp = popped_par;
    end else begin
      done_exp = 1'b0;
    end
  end

  // Send one packet; busy_hdr stalls the header, gap_at drops pl_valid for
  // three cycles after that many payload bytes (and pokes start meanwhile).
  task automatic send_pkt(input logic [1:0] d, input logic [5:0] l,
                          input logic [7:0] first, input logic [7:0] step,
                          input logic inj, input int busy_hdr, input int gap_at);
    logic [7:0] par;
    logic [7:0] b;
    exp_t       e;
    int         i;
    int         guard;
    logic       r;
    logic       seen;
    par    = {l, d};
    e.data = {l, d};
    e.pv   = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k < int'(l); k++) begin
      b      = first + 8'(step * k);
      par    = par ^ b;
      e.data = b;
      exp_q.push_back(e);
    end
    if (INJ_BUILD && inj) par = par ^ 8'h01;
    e.data = par;
    e.pv   = 1'b0;
    exp_q.push_back(e);

    @(posedge clock); #1;
    start = 1'b1; dest = d; len = l; inject_err = inj;
    @(posedge clock); #1;
    start = 1'b0; inject_err = 1'b0;
    busy = (busy_hdr > 0);
    for (int k = 0; k < busy_hdr; k++) begin
      @(posedge clock); #1;
    end
    busy     = 1'b0;
    i        = 0;
    guard    = 0;
    pl_data  = first;
    pl_valid = 1'b1;
    while (i < int'(l) && guard < 2000) begin
      @(negedge clock);
      r = pl_ready;
      @(posedge clock); #1;
      guard++;
      if (r) begin
        i++;
        pl_data = first + 8'(step * i);
        if (i == gap_at && i < int'(l)) begin
          pl_valid = 1'b0;
          for (int g = 0; g < 3; g++) begin
            start = (g == 0); dest = 2'd0; len = 6'd2;
            @(negedge clock);
            check("gap_pkt_valid", pkt_valid, 1'b0);
            check("gap_pl_ready", pl_ready, 1'b0);
            check("gap_req_err", req_err, 1'b0);
            check("gap_tx_busy", tx_busy, 1'b1);
            @(posedge clock); #1;
            start = 1'b0;
          end
          pl_valid = 1'b1;
        end
      end
    end
    pl_valid = 1'b0;
    check("payload_timeout", 16'(i), 16'(l));
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = done;
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic reject(input logic [1:0] d, input logic [5:0] l);
    @(posedge clock); #1;
    start = 1'b1; dest = d; len = l;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("rej_req_err", req_err, 1'b1);
    check("rej_tx_busy", tx_busy, 1'b0);
    check("rej_pkt_valid", pkt_valid, 1'b0);
    @(negedge clock);
    check("rej_req_err_pulse", req_err, 1'b0);
    check("rej_tx_busy2", tx_busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = '{d: 2'd1, l: 6'd3,  first: 8'hA1, step: 8'h11, inj: 1'b0, rej: 1'b0};
    vecs[1] = '{d: 2'd0, l: 6'd1,  first: 8'h55, step: 8'h00, inj: 1'b0, rej: 1'b0};
    vecs[2] = '{d: 2'd2, l: 6'(MAX_LEN), first: 8'h00, step: 8'h01, inj: 1'b0, rej: 1'b0};
    vecs[3] = '{d: 2'd3, l: 6'd4,  first: 8'h00, step: 8'h00, inj: 1'b0, rej: 1'b1};
    vecs[4] = '{d: 2'd0, l: 6'd0,  first: 8'h00, step: 8'h00, inj: 1'b0, rej: 1'b1};
    vecs[5] = '{d: 2'd2, l: 6'd7,  first: 8'hF0, step: 8'h13, inj: 1'b0, rej: 1'b0};
    vecs[6] = '{d: 2'd1, l: 6'd3,  first: 8'hA1, step: 8'h11, inj: 1'b1, rej: 1'b0};

    reset = 1'b1; start = 1'b0; dest = '0; len = '0; pl_data = '0;
    pl_valid = 1'b0; busy = 1'b0; inject_err = 1'b0;
    #12;
    check("rst_data_out", data_out, 8'h00);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_pl_ready", pl_ready, 1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_req_err", req_err, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rej) reject(vecs[v].d, vecs[v].l);
      else send_pkt(vecs[v].d, vecs[v].l, vecs[v].first, vecs[v].step, vecs[v].inj, 0, -1);
      repeat (2) @(posedge clock);
    end

    // Header stalled two cycles by busy.
    send_pkt(2'd1, 6'd3, 8'hA1, 8'h11, 1'b0, 2, -1);
    repeat (2) @(posedge clock);

    // pl_valid gap mid-payload, with an ignored start during the gap.
    send_pkt(2'd2, 6'd6, 8'h10, 8'h07, 1'b0, 0, 2);
    repeat (2) @(posedge clock);

    // Reset during PAYLOAD abandons the packet.
    e.data = {6'd5, 2'd2};
    e.pv   = 1'b1;
    exp_q.push_back(e);
    e.data = 8'h3C;
    for (int k = 0; k < 5; k++) exp_q.push_back(e);
    @(posedge clock); #1;
    start = 1'b1; dest = 2'd2; len = 6'd5;
    @(posedge clock); #1;
    start = 1'b0; pl_valid = 1'b1; pl_data = 8'h3C;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_data_out", data_out, 8'h00);
    check("mid_rst_pkt_valid", pkt_valid, 1'b0);
    check("mid_rst_pl_ready", pl_ready, 1'b0);
    check("mid_rst_tx_busy", tx_busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_req_err", req_err, 1'b0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0; pl_valid = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("post_rst_tx_busy", tx_busy, 1'b0);
      check("post_rst_data_out", data_out, 8'h00);
    end
    send_pkt(2'd0, 6'd2, 8'h5A, 8'h21, 1'b0, 0, -1);
    repeat (2) @(posedge clock);

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
